// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter in front of a single shared memory port.
// Requester 0 (core) and requester 1 (loader) are granted through an
// IDLE/GRANT0/GRANT1 FSM. A holder is preempted after MAX_BURST granted
// cycles when the other requester is waiting.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN -- simultaneous requests in
// IDLE go to the requester that was not last granted. Without it, requester 0
// always wins a tie.
module bus_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m1_req,
   input  logic [DATA_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m1_addr,
   input  logic                  m0_wren,
   input  logic                  m1_wren,
   input  logic [DATA_WIDTH-1:0] m0_wrdata,
   input  logic [DATA_WIDTH-1:0] m1_wrdata,
   output logic                  m0_gnt,
   output logic                  m1_gnt,
   output logic                  m0_rvalid,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] rddata,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wrdata,
   output logic                  mem_wren,
   input  logic [DATA_WIDTH-1:0] mem_rddata
);

   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GRANT0 = 2'd1;
   localparam logic [1:0] GRANT1 = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [1:0]       tie_pick;
   logic [CNT_W-1:0] burst_cnt;
   logic             rd0;
   logic             rd1;

   assign m0_gnt = (state == GRANT0);
   assign m1_gnt = (state == GRANT1);

   // A read completes when the granted requester asserts req with wren low.
   assign rd0 = m0_gnt && m0_req && !m0_wren;
   assign rd1 = m1_gnt && m1_req && !m1_wren;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic last_gnt;

   // Tie goes to whichever requester was not granted most recently.
   assign tie_pick = last_gnt ? GRANT0 : GRANT1;

   // Remember the requester of the most recent grant entry; 1 so m0 wins first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt <= 1'b1;
      end else if (state_nxt != state) begin
         if (state_nxt == GRANT0) last_gnt <= 1'b0;
         else if (state_nxt == GRANT1) last_gnt <= 1'b1;
      end
   end
`else
   assign tie_pick = GRANT0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state: arbitration from IDLE, hand-over on req drop or burst limit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) state_nxt = tie_pick;
            else if (m0_req)      state_nxt = GRANT0;
            else if (m1_req)      state_nxt = GRANT1;
         end
         GRANT0: begin
            if (!m0_req)                            state_nxt = m1_req ? GRANT1 : IDLE;
            else if (m1_req && burst_cnt == CNT_LAST) state_nxt = GRANT1;
         end
         GRANT1: begin
            if (!m1_req)                            state_nxt = m0_req ? GRANT0 : IDLE;
            else if (m0_req && burst_cnt == CNT_LAST) state_nxt = GRANT0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Granted-cycle counter: clears on any state change, saturates at the limit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_cnt <= '0;
      end else if (state_nxt != state) begin
         burst_cnt <= '0;
      end else if (state != IDLE && burst_cnt != CNT_LAST) begin
         burst_cnt <= burst_cnt + CNT_W'(1);
      end
   end

   // Read data capture and one-cycle valid pulse per completed read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rddata    <= '0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end else begin
         m0_rvalid <= rd0;
         m1_rvalid <= rd1;
         if (rd0 || rd1) rddata <= mem_rddata;
      end
   end

   // Shared memory port mux from the granted requester; quiet in IDLE.
   always_comb begin
      mem_addr   = '0;
      mem_wrdata = '0;
      mem_wren   = 1'b0;
      if (m0_gnt) begin
         mem_addr   = m0_addr;
         mem_wrdata = m0_wrdata;
         mem_wren   = m0_wren && m0_req;
      end else if (m1_gnt) begin
         mem_addr   = m1_addr;
         mem_wrdata = m1_wrdata;
         mem_wren   = m1_wren && m1_req;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// request traffic, compared each cycle against a cycle-level reference model.
module tb_bus_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned MB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          m0_req = 1'b0, m1_req = 1'b0;
   logic [DW-1:0] m0_addr = '0, m1_addr = '0;
   logic          m0_wren = 1'b0, m1_wren = 1'b0;
   logic [DW-1:0] m0_wrdata = '0, m1_wrdata = '0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren;
   logic [DW-1:0] rddata, mem_addr, mem_wrdata, mem_rddata;

   int checks = 0;
   int failures = 0;

   // Reference model state: current owner (-1 none), cycles held, last owner.
   int            owner;
   int            run;
   int            last;
   logic          rv0, rv1;
   logic [DW-1:0] rd;

   bus_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_wren(m0_wren), .m1_wren(m1_wren),
      .m0_wrdata(m0_wrdata), .m1_wrdata(m1_wrdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .rddata(rddata),
      .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren),
      .mem_rddata(mem_rddata)
   );

   always #5 clk = ~clk;

   // Memory content is a fixed scramble of the address.
   function automatic logic [DW-1:0] mem_f(input logic [DW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign mem_rddata = mem_f(mem_addr);

   function automatic logic req_of(input int i);
      return (i == 0) ? m0_req : m1_req;
   endfunction
   function automatic logic wren_of(input int i);
      return (i == 0) ? m0_wren : m1_wren;
   endfunction
   function automatic logic [DW-1:0] addr_of(input int i);
      return (i == 0) ? m0_addr : m1_addr;
   endfunction
   function automatic logic [DW-1:0] wdata_of(input int i);
      return (i == 0) ? m0_wrdata : m1_wrdata;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = -1;
      run   = 0;
      last  = 1;
      rv0   = 1'b0;
      rv1   = 1'b0;
      rd    = '0;
   endtask

   // Check all outputs mid-cycle, advance the model, return just after the edge.
   task automatic check_cycle();
      int   nxt;
      int   oth;
      logic xfer;
      @(negedge clk);
      chk("m0_gnt", DW'(m0_gnt), DW'(owner == 0));
      chk("m1_gnt", DW'(m1_gnt), DW'(owner == 1));
      chk("m0_rvalid", DW'(m0_rvalid), DW'(rv0));
      chk("m1_rvalid", DW'(m1_rvalid), DW'(rv1));
      chk("rddata", rddata, rd);
      chk("mem_addr", mem_addr, (owner >= 0) ? addr_of(owner) : '0);
      chk("mem_wrdata", mem_wrdata, (owner >= 0) ? wdata_of(owner) : '0);
      chk("mem_wren", DW'(mem_wren), DW'((owner >= 0) && req_of(owner) && wren_of(owner)));

      xfer = (owner >= 0) && req_of(owner);
      if (xfer && !wren_of(owner)) begin
         rv0 = (owner == 0);
         rv1 = (owner == 1);
         rd  = mem_f(addr_of(owner));
      end else begin
         rv0 = 1'b0;
         rv1 = 1'b0;
      end

      if (owner < 0) begin
         if (m0_req && m1_req) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            nxt = (last == 0) ? 1 : 0;
`else
            nxt = 0;
`endif
         end else if (m0_req) nxt = 0;
         else if (m1_req)     nxt = 1;
         else                 nxt = -1;
      end else begin
         oth = 1 - owner;
         if (!req_of(owner))                    nxt = req_of(oth) ? oth : -1;
         else if (run >= MB && req_of(oth))     nxt = oth;
         else                                   nxt = owner;
      end

      if (nxt != owner) begin
         run = (nxt >= 0) ? 1 : 0;
         if (nxt >= 0) last = nxt;
      end else if (nxt >= 0) begin
         run++;
      end
      owner = nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m1_req = 1'b0;
      m0_wren = 1'b0; m1_wren = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m0_gnt", DW'(m0_gnt), '0);
      chk("rst_m1_gnt", DW'(m1_gnt), '0);
      chk("rst_rvalid", DW'({m0_rvalid, m1_rvalid}), '0);
      chk("rst_rddata", rddata, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wrdata", mem_wrdata, '0);
      chk("rst_mem_wren", DW'(mem_wren), '0);
      rst = 1'b1;

      // Single read by m0: grant one cycle later, rvalid the cycle after.
      m0_req = 1'b1; m0_wren = 1'b0; m0_addr = 32'h0040_0000;
      check_cycle();
      chk("rd_gnt_latency", DW'(m0_gnt), DW'(1));
      check_cycle();
      m0_req = 1'b0;
      chk("rd_rvalid", DW'(m0_rvalid), DW'(1));
      chk("rd_data", rddata, mem_f(32'h0040_0000));
      check_cycle();
      check_cycle();

      // Single write by m0: one mem_wren cycle, no rvalid.
      m0_req = 1'b1; m0_wren = 1'b1; m0_addr = 32'h1001_0004; m0_wrdata = 32'hDEAD_BEEF;
      check_cycle();
      chk("wr_wren", DW'(mem_wren), DW'(1));
      chk("wr_addr", mem_addr, 32'h1001_0004);
      chk("wr_data", mem_wrdata, 32'hDEAD_BEEF);
      check_cycle();
      idle_inputs();
      chk("wr_no_rvalid", DW'(m0_rvalid), '0);
      check_cycle();
      check_cycle();

      // Tie in IDLE after m0 was last granted.
      m0_req = 1'b1; m1_req = 1'b1;
      check_cycle();
`ifdef BUS_ARB_ROUND_ROBIN_EN
      chk("tie_m1_gnt", DW'(m1_gnt), DW'(1));
`else
      chk("tie_m0_gnt", DW'(m0_gnt), DW'(1));
`endif

      // Both held: alternating MAX_BURST-long runs.
      for (int c = 0; c < 4 * MB + 2; c++) check_cycle();
      idle_inputs();
      check_cycle();
      check_cycle();

      // m1 drops while m0 waits: direct hand-over, then a full burst for m0.
      m1_req = 1'b1;
      check_cycle();
      m0_req = 1'b1;
      check_cycle();
      m1_req = 1'b0;
      check_cycle();
      chk("handover_m0_gnt", DW'(m0_gnt), DW'(1));
      m1_req = 1'b1;
      for (int c = 0; c < MB + 2; c++) check_cycle();
      idle_inputs();
      check_cycle();
      check_cycle();

      // Reset asserted mid-read in GRANT1.
      m1_req = 1'b1; m1_wren = 1'b0; m1_addr = 32'h0000_0ABC;
      check_cycle();
      check_cycle();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_gnt", DW'({m0_gnt, m1_gnt}), '0);
      chk("arst_rvalid", DW'({m0_rvalid, m1_rvalid}), '0);
      chk("arst_wren", DW'(mem_wren), '0);
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) check_cycle();

      // Randomized traffic: short holds, then long overlapping holds.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, (c < 700) ? 3 : 9) == 0) m0_req = ~m0_req;
         if ($urandom_range(0, (c < 700) ? 3 : 9) == 0) m1_req = ~m1_req;
         m0_wren   = ($urandom_range(0, 2) == 0);
         m1_wren   = ($urandom_range(0, 2) == 0);
         m0_addr   = $urandom;
         m1_addr   = $urandom;
         m0_wrdata = $urandom;
         m1_wrdata = $urandom;
         check_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of all data and address buses.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum consecutive granted cycles while the other requester waits.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have ports m0_req, m1_req  input  1 each: requester 0 (core) and requester 1 (loader) bus request.
REQ-006 SHALL have ports m0_addr, m1_addr  input  DATA_WIDTH: requester addresses.
REQ-007 SHALL have ports m0_wren, m1_wren  input  1: requester write enables.
REQ-008 SHALL have ports m0_wrdata, m1_wrdata  input  DATA_WIDTH: requester write data.
REQ-009 SHALL have ports m0_gnt, m1_gnt  output  1: grant, one-hot or both low.
REQ-010 SHALL have ports m0_rvalid, m1_rvalid  output  1: read-data-valid pulse.
REQ-011 SHALL have port rddata  output  DATA_WIDTH: registered read data, shared by both requesters.
REQ-012 SHALL have ports mem_addr, mem_wrdata  output  DATA_WIDTH, and mem_wren  output  1: shared memory port.
REQ-013 SHALL have port mem_rddata  input  DATA_WIDTH: combinational read data from memory.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT0 and GRANT1; m0_gnt = (state==GRANT0) and m1_gnt = (state==GRANT1).
REQ-015 A transfer SHALL occur on every cycle in which mX_req and mX_gnt are both high.
REQ-016 mem_addr and mem_wrdata SHALL mux combinationally from the granted requester, and SHALL be 0 in IDLE.
REQ-017 mem_wren SHALL equal mX_wren AND mX_req of the granted requester, and SHALL be 0 otherwise.
REQ-018 From IDLE, with any request asserted, the FSM SHALL enter a GRANT state on the next edge (1-cycle arbitration latency); it SHALL not grant in the same cycle.
REQ-019 In GRANTx, when reqx drops: next state SHALL be GRANTy if the other request is high, else IDLE.
REQ-020 A burst counter SHALL count granted cycles, clearing on every state change.
REQ-021 In GRANTx with reqx high, at counter == MAX_BURST-1 and the other request high: next state SHALL be GRANTy; otherwise the FSM SHALL stay in GRANTx.
REQ-022 The counter SHALL saturate at MAX_BURST-1 while no other requester waits.
REQ-023 On a granted read (wren low), rddata SHALL capture mem_rddata at that edge, and the matching mX_rvalid SHALL pulse for exactly the following cycle.
REQ-024 Back-to-back granted reads SHALL give back-to-back rvalid pulses, one result per cycle.
REQ-025 Writes SHALL produce no rvalid pulse.
REQ-026 rddata SHALL hold its last value when no read completes.
REQ-027 A last-granted pointer SHALL update on every entry into GRANT0 or GRANT1.

Reset
REQ-028 While rst is low, outputs SHALL be: state IDLE, both gnt 0, both rvalid 0, rddata 0, counter 0, mem_wren 0, mem_addr 0, mem_wrdata 0.
REQ-029 The last-granted pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-030 Reset asserted mid-burst SHALL abort the transfer immediately (asynchronous); no rvalid pulse for that transfer SHALL appear after release.

Configuration
REQ-031 With macro BUS_ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL grant the requester that was not last granted.
REQ-032 Without BUS_ARB_ROUND_ROBIN_EN, simultaneous requests in IDLE SHALL always grant requester 0 (fixed priority), and the pointer logic SHALL be omitted.
REQ-033 The MAX_BURST preemption of REQ-021 SHALL apply in both configurations.

Verification
REQ-034 Reset release, m0_req=1 read at 0x00400000 -> m0_gnt high 1 cycle later; m0_rvalid high the cycle after, with rddata = memory word.
REQ-035 m0 write addr 0x10010004 data 0xDEADBEEF -> one mem_wren cycle with those values, and no rvalid.
REQ-036 m0_req and m1_req held high, MAX_BURST=4 -> grants alternate in 4-cycle runs: GRANT0 x4, GRANT1 x4, ...
REQ-037 Both requests rise together in IDLE twice, last grant m0 -> second tie grants m1 with BUS_ARB_ROUND_ROBIN_EN, m0 without it.
REQ-038 m1 drops req while m0 waits -> GRANT0 on the next edge with no IDLE cycle; counter = 0.
REQ-039 rst driven low during a GRANT1 read -> gnt, rvalid and mem_wren drop immediately, and stay 0 after release until a new request.
